// File: rtl/orbit_ball.sv
// orbit_ball: keyboard-steered ball orbiting a fixed centre.
// Position table is built at elaboration from a Q1.10 sine table.
module orbit_ball #(
  parameter int          STEPS        = 60,
  parameter int          RADIUS       = 80,
  parameter int          CX           = 320,
  parameter int          CY           = 240,
  parameter int          START_IDX    = 0,
  parameter logic [7:0]  KEY_CW       = 8'h07,
  parameter logic [7:0]  KEY_CCW      = 8'h04,
  parameter int          ACCEL_FRAMES = 8,
  parameter int          MAX_SPEED    = 3,
  parameter int          BALL_SIZE    = 4,
  localparam int         IW           = $clog2(STEPS),
  localparam int         SW           = $clog2(MAX_SPEED + 1)
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic [7:0]    keycode,
  input  logic          alive,
  output logic [9:0]    ball_x,
  output logic [9:0]    ball_y,
  output logic [9:0]    ball_s,
  output logic [IW-1:0] index,
  output logic          moving,
  output logic [SW-1:0] speed
);

  localparam int HMAX = ACCEL_FRAMES * (MAX_SPEED - 1);
  localparam int HW   = $clog2(HMAX + 2);

  typedef enum logic [1:0] {D_NONE, D_CW, D_CCW} dir_e;

  // round(1024*sin(2*pi*i/STEPS)) via first-quadrant Taylor series in Q30
  function automatic int sin_q(input int i);
    longint x, t, s;
    int q, quad, j;
    q    = STEPS / 4;
    quad = (i / q) % 4;
    j    = i % q;
    if (quad == 1 || quad == 3) j = q - j;
    x = (longint'(j) * 64'sd6746518852) / longint'(STEPS);
    t = x;
    s = x;
    for (int k = 1; k < 12; k++) begin
      t = (t * x) >>> 30;
      t = (t * x) >>> 30;
      t = -t / longint'((2 * k) * (2 * k + 1));
      s = s + t;
    end
    j = int'((s * 1024 + (longint'(1) <<< 29)) >>> 30);
    return (quad >= 2) ? -j : j;
  endfunction

  function automatic logic [9:0] pos_x(input int i);
    int c;
    c = sin_q((i + STEPS / 4) % STEPS);
    return 10'(CX + ((RADIUS * c + 512) >>> 10));
  endfunction

  function automatic logic [9:0] pos_y(input int i);
    int s;
    s = sin_q(i);
    return 10'(CY - ((RADIUS * s + 512) >>> 10));
  endfunction

  function automatic logic [SW-1:0] spd_of(input logic [HW-1:0] h);
    int l;
    l = int'(h) / ACCEL_FRAMES;
    if (l > MAX_SPEED - 1) l = MAX_SPEED - 1;
    return SW'(l + 1);
  endfunction

  localparam logic [9:0] X0 = pos_x(START_IDX);
  localparam logic [9:0] Y0 = pos_y(START_IDX);

  logic [9:0] w_tx [0:STEPS-1];
  logic [9:0] w_ty [0:STEPS-1];

  for (genvar g = 0; g < STEPS; g++) begin : g_tab
    localparam logic [9:0] PX = pos_x(g);
    localparam logic [9:0] PY = pos_y(g);
    assign w_tx[g] = PX;
    assign w_ty[g] = PY;
  end

  dir_e          r_pdir, w_dir;
  logic [HW-1:0] r_hold, w_hold;
  logic [SW-1:0] r_spd, w_spd;
  logic [IW-1:0] r_idx, w_nidx;
  logic [IW:0]   w_up;
  logic [9:0]    r_x, r_y;
  logic          r_mov;

  always_comb begin
    w_dir = D_NONE;
    unique case (1'b1)
      keycode == KEY_CW:  w_dir = D_CW;
      keycode == KEY_CCW: w_dir = D_CCW;
      default:            w_dir = D_NONE;
    endcase
    if (!alive) w_dir = D_NONE;

    // counter already includes this edge, so the first held edge is speed 1
    w_hold = '0;
    if (w_dir != D_NONE && w_dir == r_pdir)
      w_hold = (r_hold == HW'(HMAX)) ? r_hold : r_hold + 1'b1;
    w_spd = spd_of(w_hold);

    w_up   = {1'b0, r_idx} + (IW+1)'(w_spd);
    w_nidx = r_idx;
    unique case (w_dir)
      D_CCW:
        w_nidx = (w_up >= (IW+1)'(STEPS)) ?
                 IW'(w_up - (IW+1)'(STEPS)) : IW'(w_up);
      D_CW:
        w_nidx = ({1'b0, r_idx} >= (IW+1)'(w_spd)) ?
                 r_idx - IW'(w_spd) :
                 IW'({1'b0, r_idx} + (IW+1)'(STEPS) - (IW+1)'(w_spd));
      default:
        w_nidx = r_idx;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_idx  <= IW'(START_IDX);
      r_x    <= X0;
      r_y    <= Y0;
      r_spd  <= SW'(1);
      r_hold <= '0;
      r_pdir <= D_NONE;
      r_mov  <= 1'b0;
    end else begin
      r_idx  <= w_nidx;
      r_x    <= w_tx[w_nidx];
      r_y    <= w_ty[w_nidx];
      r_spd  <= w_spd;
      r_hold <= w_hold;
      r_pdir <= w_dir;
      r_mov  <= (w_nidx != r_idx);
    end
  end

  assign index  = r_idx;
  assign ball_x = r_x;
  assign ball_y = r_y;
  assign ball_s = 10'(BALL_SIZE);
  assign moving = r_mov;
  assign speed  = r_spd;

endmodule

// File: tb/tb_orbit_ball.sv
// tb_orbit_ball: two orbit_ball instances (start 0 and 30) against
// a real-arithmetic orbit model, directed then randomized key streams.
module tb_orbit_ball;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       alive;

  logic [9:0] x0, y0, s0, x1, y1, s1;
  logic [5:0] idx0, idx1;
  logic       mov0, mov1;
  logic [1:0] spd0, spd1;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 frame_clk = ~frame_clk;

  orbit_ball u_d0 (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .alive(alive), .ball_x(x0), .ball_y(y0), .ball_s(s0),
    .index(idx0), .moving(mov0), .speed(spd0)
  );

  orbit_ball #(.START_IDX(30)) u_d1 (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .alive(alive), .ball_x(x1), .ball_y(y1), .ball_s(s1),
    .index(idx1), .moving(mov1), .speed(spd1)
  );

  function automatic int sinq(input int i);
    real v;
    v = 1024.0 * $sin(2.0 * 3.14159265358979 * i / 60.0);
    return (v >= 0.0) ? $rtoi($floor(v + 0.5)) : -$rtoi($floor(-v + 0.5));
  endfunction

  function automatic int mx(input int i);
    return 320 + ((80 * sinq((i + 15) % 60) + 512) >>> 10);
  endfunction

  function automatic int my(input int i);
    return 240 - ((80 * sinq(i) + 512) >>> 10);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // model: run = consecutive edges with the same live direction
  int m_idx [2];
  int m_mov, m_spd, m_pdir, m_run;
  int start_of [2] = '{0, 30};

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int u = 0; u < 2; u++) m_idx[u] = start_of[u];
      m_mov = 0; m_spd = 1; m_pdir = 0; m_run = 0;
    end else begin
      int d, old;
      d = !alive ? 0 : (keycode == 8'h07) ? -1 :
          (keycode == 8'h04) ? 1 : 0;
      if (d == 0) m_run = 0;
      else if (d == m_pdir) m_run++;
      else m_run = 1;
      m_spd = (d == 0) ? 1 : 1 + (((m_run - 1) / 8 > 2) ? 2 : (m_run - 1) / 8);
      old = m_idx[0];
      for (int u = 0; u < 2; u++)
        m_idx[u] = (((m_idx[u] + d * m_spd) % 60) + 60) % 60;
      m_mov = (m_idx[0] != old) ? 1 : 0;
      m_pdir = d;
    end
  end

  always @(negedge frame_clk) begin
    if (chk_en && !Reset) begin
      chk("d0_idx", int'(idx0), m_idx[0]);
      chk("d0_x", int'(x0), mx(m_idx[0]));
      chk("d0_y", int'(y0), my(m_idx[0]));
      chk("d0_mov", int'(mov0), m_mov);
      chk("d0_spd", int'(spd0), m_spd);
      chk("d1_idx", int'(idx1), m_idx[1]);
      chk("d1_x", int'(x1), mx(m_idx[1]));
      chk("d1_y", int'(y1), my(m_idx[1]));
      chk("d1_mov", int'(mov1), m_mov);
      chk("d1_s", int'(s1), 4);
    end
  end

  task automatic tick(input logic [7:0] k, input logic al);
    keycode = k;
    alive   = al;
    @(negedge frame_clk);
  endtask

  task automatic rst_lits();
    chk("rst_idx0", int'(idx0), 0);
    chk("rst_x0", int'(x0), 400);
    chk("rst_y0", int'(y0), 240);
    chk("rst_s0", int'(s0), 4);
    chk("rst_spd0", int'(spd0), 1);
    chk("rst_mov0", int'(mov0), 0);
    chk("rst_idx1", int'(idx1), 30);
    chk("rst_x1", int'(x1), 240);
    chk("rst_y1", int'(y1), 240);
  endtask

  // asynchronous pulse between edges; outputs must settle before next edge
  task automatic rst_pulse();
    #2 Reset = 1'b1;
    #1 rst_lits();
    #1 Reset = 1'b0;
  endtask

  initial begin
    int hold_left;
    logic [7:0] k;
    Reset = 1'b1; keycode = 8'h00; alive = 1'b1;
    repeat (2) @(negedge frame_clk);
    chk("model_x59", mx(59), 400);
    chk("model_y59", my(59), 248);
    rst_lits();
    Reset = 1'b0;
    chk_en = 1'b1;

    tick(8'h07, 1'b1);
    chk("cw_idx", int'(idx0), 59);
    chk("cw_x", int'(x0), 400);
    chk("cw_y", int'(y0), 248);
    chk("cw_mov", int'(mov0), 1);
    tick(8'h00, 1'b1);
    chk("rel_idx", int'(idx0), 59);
    chk("rel_mov", int'(mov0), 0);

    rst_pulse();
    repeat (15) begin
      tick(8'h04, 1'b1);
      tick(8'h00, 1'b1);
    end
    chk("tap_idx", int'(idx0), 15);
    chk("tap_x", int'(x0), 320);
    chk("tap_y", int'(y0), 160);

    rst_pulse();
    for (int n = 1; n <= 29; n++) begin
      tick(8'h04, 1'b1);
      if (n == 8)  chk("acc8", int'(idx0), 8);
      if (n == 16) chk("acc16", int'(idx0), 24);
      if (n == 24) chk("acc24", int'(idx0), 48);
      if (n == 28) chk("acc28", int'(idx0), 0);
      if (n == 29) chk("acc29", int'(idx0), 3);
    end
    chk("acc_spd", int'(spd0), 3);
    tick(8'h07, 1'b1);
    chk("rev_idx", int'(idx0), 2);
    chk("rev_spd", int'(spd0), 1);
    repeat (3) tick(8'h07, 1'b1);
    chk("rev3_idx", int'(idx0), 59);
    repeat (5) begin
      tick(8'h07, 1'b0);
      chk("dead_idx", int'(idx0), 59);
      chk("dead_mov", int'(mov0), 0);
      chk("dead_spd", int'(spd0), 1);
    end
    tick(8'h07, 1'b1);
    chk("revive_idx", int'(idx0), 58);

    repeat (10) tick(8'h07, 1'b1);
    rst_pulse();
    tick(8'h07, 1'b1);
    chk("post_rst_idx", int'(idx0), 59);
    repeat (3) begin
      tick(8'h1A, 1'b1);
      chk("unmap_idx", int'(idx0), 59);
      chk("unmap_mov", int'(mov0), 0);
    end

    hold_left = 0;
    k = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if (hold_left == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: k = 8'h04;
          4, 5, 6:    k = 8'h07;
          7:          k = 8'h00;
          8:          k = 8'h1A;
          default:    k = 8'($urandom);
        endcase
        hold_left = $urandom_range(1, 24);
      end
      hold_left--;
      if ($urandom_range(0, 79) == 0) begin
        #2 Reset = 1'b1;
        #1 Reset = 1'b0;
      end
      tick(k, ($urandom_range(0, 19) != 0));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
